dmem_responder: RTL and testbench

DMEM_RESPONDER -- requirements
Module: dmem_responder

---
 rtl/dmem_responder_if.sv | 36 +++
 rtl/dmem_responder.sv | 188 ++++++++++++++++++
 tb/tb_dmem_responder.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_responder_if.sv
// MEM-stage data-memory bus between the pipeline (master) and the responder (slave).
interface dmem_responder_if;
    // Request side, driven by the pipeline
    logic        MemReqM;
    logic        MemWriteM;
    logic        ByteM;
    logic [31:0] ALUResultM;
    logic [31:0] WriteDataM;

    // Response side, driven by the memory responder
    logic [31:0] ReadDataM;
    logic        MemStallM;
    logic        MemErrM;

    modport master (
        output MemReqM,
        output MemWriteM,
        output ByteM,
        output ALUResultM,
        output WriteDataM,
        input  ReadDataM,
        input  MemStallM,
        input  MemErrM
    );

    modport slave (
        input  MemReqM,
        input  MemWriteM,
        input  ByteM,
        input  ALUResultM,
        input  WriteDataM,
        output ReadDataM,
        output MemStallM,
        output MemErrM
    );
endinterface

// File: rtl/dmem_responder.sv
// Multi-cycle data memory responder for a pipelined core's MEM stage.
// A request is captured in IDLE, held for WAIT_CYCLES extra cycles in BUSY,
// committed on the BUSY->DONE edge, and its response is presented for one
// DONE cycle. The pipeline is stalled from acceptance until DONE.
module dmem_responder #(
    parameter int unsigned DEPTH_WORDS = 64,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input logic            clk,
    input logic            reset,
    dmem_responder_if.slave bus
);

    localparam int unsigned IdxW = $clog2(DEPTH_WORDS);
    localparam int unsigned AddrW = IdxW + 2;
    localparam logic [3:0] WaitLoad = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {
        StIdle,
        StBusy,
        StDone
    } state_e;

    state_e state_q, state_d;

    // Wait-state counter
    logic [3:0] cnt_q, cnt_d;

    // Latched request; only the address bits that select a word and lane are kept
    logic [AddrW-1:0] addr_q;
    logic [31:0]      wdata_q;
    logic             write_q;
    logic             byte_q;

    // Registered response
    logic [31:0] rdata_q;
    logic        err_q;

    // Storage; deliberately never reset
    logic [31:0] mem [DEPTH_WORDS];

    // Address bits above the wrapped word index are ignored by design
    logic unused_addr_hi;
    assign unused_addr_hi = ^bus.ALUResultM[31:AddrW];

    // Decoded control
    logic             accept;
    logic             commit;
    logic             misaligned;
    logic [IdxW-1:0]  idx;
    logic [1:0]       lane;
    logic [3:0]       byte_en;
    logic [31:0]      wdata_lanes;
    logic [31:0]      mem_word;
    logic [7:0]       mem_lane;
    logic [31:0]      load_data;

    assign accept = (state_q == StIdle) && bus.MemReqM;
    assign commit = (state_q == StBusy) && (cnt_q == 4'd0);

    assign idx  = addr_q[AddrW-1:2];
    assign lane = addr_q[1:0];

    // Word accesses must be word-aligned; byte accesses may target any lane
    assign misaligned = !byte_q && (lane != 2'b00);

    // Lane enables and replicated byte data for stores
    always_comb begin
        byte_en     = 4'b1111;
        wdata_lanes = wdata_q;
        if (byte_q) begin
            byte_en     = 4'b0001 << lane;
            wdata_lanes = {4{wdata_q[7:0]}};
        end
    end

    // Read path: selected word, selected lane, and the value to register
    always_comb begin
        mem_word = mem[idx];
        mem_lane = 8'h00;
        unique case (lane)
            2'd0:    mem_lane = mem_word[7:0];
            2'd1:    mem_lane = mem_word[15:8];
            2'd2:    mem_lane = mem_word[23:16];
            2'd3:    mem_lane = mem_word[31:24];
            default: mem_lane = 8'h00;
        endcase
        if (misaligned) begin
            load_data = 32'h0;
        end else if (byte_q) begin
            load_data = {24'h0, mem_lane};
        end else begin
            load_data = mem_word;
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; DONE never accepts, giving one bubble between requests
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (bus.MemReqM) begin
                    state_d = StBusy;
                end
            end
            StBusy: begin
                if (cnt_q == 4'd0) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Wait counter next value: load on accept, count down in BUSY
    always_comb begin
        cnt_d = cnt_q;
        if (accept) begin
            cnt_d = WaitLoad;
        end else if ((state_q == StBusy) && (cnt_q != 4'd0)) begin
            cnt_d = cnt_q - 4'd1;
        end
    end

    // Request capture, counter and response registers
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q   <= 4'd0;
            addr_q  <= '0;
            wdata_q <= 32'h0;
            write_q <= 1'b0;
            byte_q  <= 1'b0;
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            if (accept) begin
                addr_q  <= bus.ALUResultM[AddrW-1:0];
                wdata_q <= bus.WriteDataM;
                write_q <= bus.MemWriteM;
                byte_q  <= bus.ByteM;
            end
            if (commit) begin
                rdata_q <= write_q ? 32'h0 : load_data;
                err_q   <= misaligned;
            end
        end
    end

    // Memory write at commit; reset at the same edge cancels it
    always_ff @(posedge clk) begin
        if (!reset && commit && write_q && !misaligned) begin
            for (int i = 0; i < 4; i++) begin
                if (byte_en[i]) begin
                    mem[idx][8*i +: 8] <= wdata_lanes[8*i +: 8];
                end
            end
        end
    end

    // Outputs: stall covers the accepting IDLE cycle and all of BUSY
    always_comb begin
        bus.MemStallM = ((state_q == StIdle) && bus.MemReqM) || (state_q == StBusy);
        bus.ReadDataM = 32'h0;
        bus.MemErrM   = 1'b0;
        if (state_q == StDone) begin
            bus.MemErrM = err_q;
            if (!write_q) begin
                bus.ReadDataM = rdata_q;
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: the driver pushes model expectations,
// a negedge monitor pops them whenever the DUT ends a stall run with DONE.
module tb_dmem_responder;

    localparam int Depth = 64;
    localparam int Wait  = 2;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    dmem_responder_if bus ();
    dmem_responder_if bus0 ();

    dmem_responder #(.DEPTH_WORDS(Depth), .WAIT_CYCLES(Wait)) u_dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    dmem_responder #(.DEPTH_WORDS(Depth), .WAIT_CYCLES(0)) u_dut0 (
        .clk  (clk),
        .reset(reset),
        .bus  (bus0)
    );

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          stalls;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] model_mem [Depth];
    int          vectors = 0;
    int          miscompares = 0;

    function automatic void check32(input string name, input logic [31:0] act,
                                    input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // Behavioural memory: word array indexed modulo depth, byte lanes by shifting
    function automatic exp_t model_access(input logic wr, input logic byt,
                                          input logic [31:0] addr, input logic [31:0] data);
        exp_t e;
        int   idx;
        int   sh;
        idx      = int'((addr >> 2) % Depth);
        sh       = 8 * int'(addr % 4);
        e.stalls = Wait + 2;
        e.err    = 1'b0;
        e.rdata  = 32'h0;
        if (!byt && (addr % 4) != 0) begin
            e.err = 1'b1;
        end else if (wr) begin
            if (byt) begin
                model_mem[idx] = (model_mem[idx] & ~(32'hFF << sh)) | ((data & 32'hFF) << sh);
            end else begin
                model_mem[idx] = data;
            end
        end else if (byt) begin
            e.rdata = (model_mem[idx] >> sh) & 32'hFF;
        end else begin
            e.rdata = model_mem[idx];
        end
        return e;
    endfunction

    // Monitor: a stall run followed by a non-stall cycle is a DONE cycle
    int run = 0;
    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            run = 0;
        end else if (bus.MemStallM) begin
            run++;
            check32("busy_rdata_zero", bus.ReadDataM, 32'h0);
        end else if (run > 0) begin
            if (sb.size() == 0) begin
                check32("unexpected_done", 32'(run), 32'h0);
            end else begin
                e = sb.pop_front();
                check32("done_rdata", bus.ReadDataM, e.rdata);
                check32("done_err", {31'h0, bus.MemErrM}, {31'h0, e.err});
                check32("stall_cycles", 32'(run), 32'(e.stalls));
            end
            run = 0;
        end else begin
            check32("idle_rdata_zero", bus.ReadDataM, 32'h0);
            check32("idle_err_zero", {31'h0, bus.MemErrM}, 32'h0);
        end
    end

    // Called at posedge+1; returns at posedge+1 of the cycle after DONE with the
    // request still asserted so that back-to-back calls exercise held MemReqM.
    task automatic access(input logic wr, input logic byt, input logic [31:0] addr,
                          input logic [31:0] data, input bit scramble);
        bit seen;
        bit done;
        sb.push_back(model_access(wr, byt, addr, data));
        bus.MemReqM    = 1'b1;
        bus.MemWriteM  = wr;
        bus.ByteM      = byt;
        bus.ALUResultM = addr;
        bus.WriteDataM = data;
        seen = 1'b0;
        done = 1'b0;
        for (int k = 0; k < 60 && !done; k++) begin
            @(negedge clk);
            if (bus.MemStallM) begin
                seen = 1'b1;
            end else if (seen) begin
                done = 1'b1;
            end
            if (scramble && seen && !done) begin
                @(posedge clk);
                #1;
                bus.MemReqM    = 1'($urandom);
                bus.MemWriteM  = 1'($urandom);
                bus.ByteM      = 1'($urandom);
                bus.ALUResultM = $urandom;
                bus.WriteDataM = $urandom;
            end
        end
        if (!done) begin
            check32("access_timeout", 32'h1, 32'h0);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycles(input int n);
        bus.MemReqM = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Present a store, then assert reset after 'busy_cycles' BUSY cycles
    task automatic aborted_store(input logic [31:0] addr, input logic [31:0] data,
                                 input int busy_cycles);
        bus.MemReqM    = 1'b1;
        bus.MemWriteM  = 1'b1;
        bus.ByteM      = 1'b0;
        bus.ALUResultM = addr;
        bus.WriteDataM = data;
        repeat (busy_cycles) begin
            @(posedge clk);
            #1;
        end
        reset       = 1'b1;
        bus.MemReqM = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check32("abort_stall_low", {31'h0, bus.MemStallM}, 32'h0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus.MemReqM     = 1'b0;
        bus.MemWriteM   = 1'b0;
        bus.ByteM       = 1'b0;
        bus.ALUResultM  = 32'h0;
        bus.WriteDataM  = 32'h0;
        bus0.MemReqM    = 1'b0;
        bus0.MemWriteM  = 1'b0;
        bus0.ByteM      = 1'b0;
        bus0.ALUResultM = 32'h0;
        bus0.WriteDataM = 32'h0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check32("reset_rdata", bus.ReadDataM, 32'h0);
        check32("reset_err", {31'h0, bus.MemErrM}, 32'h0);
        check32("reset_stall", {31'h0, bus.MemStallM}, 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Give every word a known value so the model and DUT agree
        for (int i = 0; i < Depth; i++) begin
            access(1'b1, 1'b0, 32'(i * 4), 32'h0, 1'b0);
        end
        idle_cycles(2);

        // Word round trip
        access(1'b1, 1'b0, 32'h10, 32'hDEADBEEF, 1'b0);
        access(1'b0, 1'b0, 32'h10, 32'h0, 1'b0);
        idle_cycles(1);

        // Byte lanes
        access(1'b1, 1'b0, 32'h20, 32'h11223344, 1'b0);
        access(1'b1, 1'b1, 32'h22, 32'h000000AA, 1'b0);
        access(1'b0, 1'b0, 32'h20, 32'h0, 1'b0);
        access(1'b0, 1'b1, 32'h23, 32'h0, 1'b0);

        // Misaligned load and store leave memory untouched
        access(1'b0, 1'b0, 32'h21, 32'h0, 1'b0);
        access(1'b0, 1'b0, 32'h20, 32'h0, 1'b0);
        access(1'b1, 1'b0, 32'h26, 32'hCAFEF00D, 1'b0);
        access(1'b0, 1'b0, 32'h24, 32'h0, 1'b0);

        // Address wrap
        access(1'b1, 1'b0, 32'h100, 32'h5, 1'b0);
        access(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        idle_cycles(1);

        // Reset in the second BUSY cycle, then reset on the commit edge
        aborted_store(32'h30, 32'hFFFFFFFF, 2);
        access(1'b0, 1'b0, 32'h30, 32'h0, 1'b0);
        idle_cycles(1);
        aborted_store(32'h34, 32'hA5A5A5A5, 3);
        access(1'b0, 1'b0, 32'h34, 32'h0, 1'b0);
        idle_cycles(1);

        // Reset wins over a request at the same edge
        bus.MemReqM = 1'b1;
        reset       = 1'b1;
        @(posedge clk);
        #1;
        reset       = 1'b0;
        bus.MemReqM = 1'b0;
        @(negedge clk);
        check32("reset_beats_req", {31'h0, bus.MemStallM}, 32'h0);
        @(posedge clk);
        #1;

        // Random traffic, some with inputs changing while BUSY
        for (int n = 0; n < 300; n++) begin
            logic        wr;
            logic        byt;
            logic [31:0] addr;
            wr   = 1'($urandom);
            byt  = 1'($urandom);
            addr = $urandom_range(0, 32'h3FF);
            if ($urandom_range(0, 3) != 0 && !byt) begin
                addr[1:0] = 2'b00;
            end
            access(wr, byt, addr, $urandom, ($urandom_range(0, 3) == 0));
            if ($urandom_range(0, 2) == 0) begin
                idle_cycles($urandom_range(1, 3));
            end
        end
        idle_cycles(3);

        // Zero wait states with MemReqM held: stall pattern 1,1,0 repeating
        bus0.MemReqM    = 1'b1;
        bus0.MemWriteM  = 1'b1;
        bus0.ByteM      = 1'b0;
        bus0.ALUResultM = 32'h8;
        bus0.WriteDataM = $urandom;
        for (int k = 0; k < 9; k++) begin
            @(negedge clk);
            check32("w0_stall", {31'h0, bus0.MemStallM}, (k % 3 == 2) ? 32'h0 : 32'h1);
            check32("w0_rdata", bus0.ReadDataM, 32'h0);
        end
        @(posedge clk);
        #1;
        bus0.MemReqM = 1'b0;

        repeat (4) @(posedge clk);
        check32("scoreboard_empty", 32'(sb.size()), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
